alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue sequencer in front of the single-cycle ALU. Accepts decoded idu1_out_t ops from IDU1 via valid/ready.
//  Holds an op while its sources are hazarded: by a long-latency unit (scoreboard) or by the ALU result still in flight.
//  Inserts the branch-resolve bubble and flushes the wrong-path op when the ALU redirects the PC.
// PARAMETERS
//  XLEN      32  datapath width
//  NUM_REGS  32  architectural registers tracked by the scoreboard (x0 never tracked)
// PORTS
//  clk              in   1             clock; single clock domain
//  rst              in   1             reset, synchronous, active-high
//  in_valid         in   1             IDU1 presents an op
//  in_ctrl          in   idu1_out_t    decoded op
//  in_ready         out  1             op accepted when in_valid & in_ready
//  alu_ctrl         out  idu1_out_t    op driven to ALU; all-zero with .nop=1 when no issue
//  alu_issue        out  1             alu_ctrl carries a real op this cycle
//  sb_set_valid     in   1             long-latency op dispatched; mark rd pending
//  sb_set_addr      in   5             its rd
//  sb_clr_valid     in   1             long-latency writeback; clear pending
//  sb_clr_addr      in   5             its rd
//  alu_wb_data      in   XLEN          registered ALU result (forwarding source)
//  alu_wb_rd_addr   in   5             registered ALU rd
//  alu_wb_rd_wr_en  in   1             registered ALU write enable
//  alu_pc_load      in   1             registered ALU redirect (valid the cycle after a jal/condbr issues)
//  flush            out  1             one-cycle pulse: front end discards in-flight ops
// BEHAVIOUR
//  Reset: state=IDLE, hold buffer empty, scoreboard all clear, in_ready=0 during rst and 1 the cycle after; alu_issue=0; flush=0.
//  Hold buffer: 1 entry. in_ready = ~hold_full | issue_now (same-cycle replace allowed). Zero-bubble when no hazard.
//  Hazard = (rs1 & pend[rs1_addr]) | (rs2 & pend[rs2_addr]) | raw_alu. Ops are never issued while hazard=1.
//  raw_alu = previous issued op wrote rd!=0 and current rs1/rs2 matches it (only without ALU_FWD_EN).
//  Scoreboard: set and clr same addr same cycle -> set wins (new producer). Addr 0 ignored. Set by this cycle visible next cycle.
//  States: IDLE -> (issue jal|condbr) -> RESOLVE -> IDLE. RESOLVE lasts exactly one cycle; no issue in RESOLVE.
//   RESOLVE & alu_pc_load: hold buffer dropped, flush=1, any op accepted this cycle also dropped.
//   RESOLVE & ~alu_pc_load: buffered op issues normally from next cycle.
//  Scoreboard is not cleared by flush (long-latency ops older than the branch still retire).
//  Issue latency: accept to alu_issue = 0 cycles when no hazard; the ALU result follows 1 cycle later.
//  Reset mid-RESOLVE: pending redirect is abandoned, flush stays 0.
// CONFIGURATION
//  ALU_FWD_EN defined: rs1_data/rs2_data in alu_ctrl are replaced by alu_wb_data when alu_wb_rd_wr_en &
//   alu_wb_rd_addr!=0 & addr match; raw_alu hazard is removed. Back-to-back dependent ALU ops issue with no bubble.
//  ALU_FWD_EN undefined: alu_wb_* inputs unused; dependent op stalls exactly 1 cycle.
// STRUCTURE
//  types.svh: alu_issue_state_e {IDLE, RESOLVE}; reuse idu1_out_t; localparam SB_W = NUM_REGS.
//  Sub-module alu_scoreboard: NUM_REGS-bit pending vector, set/clr ports, two combinational read ports.
//  State/hold registers built from dff_rst-style flops with synchronous active-high reset.
// TESTING
//  add x1,x2,x3 then add x4,x1,x1 -> no fwd: alu_issue 1,0,1; ALU_FWD_EN: 1,1 with rs1_data=rs2_data=alu_wb_data.
//  sb_set x5; add x6,x5,x0 held; sb_clr x5 at cycle 4 -> op issues cycle 5, in_ready=0 while held.
//  beq taken (alu_pc_load=1 in RESOLVE) with next op valid -> flush=1 one cycle, next op never issues.
//  bne not taken -> one bubble, following add issues in cycle after RESOLVE, flush=0.
//  sb_set and sb_clr both addr 7 same cycle -> pend[7]=1; op reading x7 stalls.
//  rst asserted during RESOLVE with alu_pc_load=1 -> flush=0, alu_issue=0, scoreboard clear next cycle.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_pkg
//   Shared types and constants for the ALU issue sequencer slice.
//   - XLEN / NUM_REGS : datapath width and scoreboard depth
//   - idu1_out_t      : decoded op handed from IDU1 to the ALU
//   - alu_issue_state_e : sequencer FSM states
//   - nop_ctrl()      : the bubble value driven to the ALU when nothing issues
//   - fwd_operands()  : replaces source data with the in-flight ALU result
// ---------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int SB_W     = NUM_REGS;
    localparam int REG_AW   = $clog2(NUM_REGS);

    typedef enum logic {
        IDLE    = 1'b0,
        RESOLVE = 1'b1
    } alu_issue_state_e;

    typedef struct packed {
        logic              nop;
        logic              jal;
        logic              condbr;
        logic              rs1;       // rs1 is read by this op
        logic              rs2;       // rs2 is read by this op
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic              rd_wr_en;
        logic [REG_AW-1:0] rd_addr;
        logic [3:0]        alu_op;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } idu1_out_t;

    // All-zero op with only .nop set: what the ALU sees in a bubble.
    function automatic idu1_out_t nop_ctrl();
        idu1_out_t c;
        c     = '0;
        c.nop = 1'b1;
        return c;
    endfunction

    // Substitute the registered ALU result for any source that names its rd.
    // x0 is never forwarded because it is never really written.
    function automatic idu1_out_t fwd_operands(
        input idu1_out_t         op,
        input logic              wb_wr_en,
        input logic [REG_AW-1:0] wb_rd_addr,
        input logic [XLEN-1:0]   wb_data
    );
        idu1_out_t r;
        r = op;
        if (wb_wr_en && (wb_rd_addr != '0)) begin
            if (op.rs1_addr == wb_rd_addr) r.rs1_data = wb_data;
            if (op.rs2_addr == wb_rd_addr) r.rs2_data = wb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
//   Bundles every non-clock signal of the ALU issue sequencer.
//   IDU1 side : in_valid, in_ctrl, in_ready
//   ALU side  : alu_ctrl, alu_issue, alu_wb_data/rd_addr/rd_wr_en, alu_pc_load
//   Long-latency scoreboard updates : sb_set_valid/addr, sb_clr_valid/addr
//   Front end : flush
//   Modports: slave = the sequencer, master = its environment.
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if;
    import alu_issue_ctrl_pkg::*;

    logic              in_valid;
    idu1_out_t         in_ctrl;
    logic              in_ready;
    idu1_out_t         alu_ctrl;
    logic              alu_issue;
    logic              sb_set_valid;
    logic [REG_AW-1:0] sb_set_addr;
    logic              sb_clr_valid;
    logic [REG_AW-1:0] sb_clr_addr;
    logic [XLEN-1:0]   alu_wb_data;
    logic [REG_AW-1:0] alu_wb_rd_addr;
    logic              alu_wb_rd_wr_en;
    logic              alu_pc_load;
    logic              flush;

    modport slave (
        input  in_valid, in_ctrl,
        output in_ready,
        output alu_ctrl, alu_issue,
        input  sb_set_valid, sb_set_addr, sb_clr_valid, sb_clr_addr,
        input  alu_wb_data, alu_wb_rd_addr, alu_wb_rd_wr_en, alu_pc_load,
        output flush
    );

    modport master (
        output in_valid, in_ctrl,
        input  in_ready,
        input  alu_ctrl, alu_issue,
        output sb_set_valid, sb_set_addr, sb_clr_valid, sb_clr_addr,
        output alu_wb_data, alu_wb_rd_addr, alu_wb_rd_wr_en, alu_pc_load,
        input  flush
    );

endinterface

// File: rtl/alu_issue_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_scoreboard  (the ALU scoreboard)
//   One pending bit per architectural register, marking registers whose
//   producer is a long-latency unit that has not written back yet.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     set_valid / set_addr  : mark rd pending (producer dispatched)
//     clr_valid / clr_addr  : clear rd pending (producer wrote back)
//     rd_addr_a / pend_a    : combinational read port A
//     rd_addr_b / pend_b    : combinational read port B
//   x0 is never marked. Updates become visible the cycle after they occur.
// ---------------------------------------------------------------------------
module alu_issue_ctrl_scoreboard
    import alu_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_valid,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic              pend_a,
    output logic              pend_b
);

    logic [SB_W-1:0] pend_q;
    logic [SB_W-1:0] pend_d;

    // Clear first, then set: a new producer dispatched in the same cycle as
    // the old one's writeback must leave the register pending.
    always_comb begin
        // NOTE: start from the held value so every path assigns pend_d and no latch is inferred.
        pend_d = pend_q;
        if (clr_valid && (clr_addr != '0)) pend_d[clr_addr] = 1'b0;
        if (set_valid && (set_addr != '0)) pend_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples values from before the edge.
            pend_q <= pend_d;
        end
    end

    assign pend_a = pend_q[rd_addr_a];
    assign pend_b = pend_q[rd_addr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue sequencer in front of the single-cycle ALU.
//   - Accepts decoded ops from IDU1 (valid/ready) through a 1-entry hold
//     buffer; with no hazard an op issues in the cycle it is accepted.
//   - Stalls while a source is pending in the long-latency scoreboard, or
//     (without forwarding) while it depends on the ALU op issued last cycle.
//   - After a jal/condbr issues, spends one RESOLVE cycle with no issue;
//     if the ALU redirects then, the buffered op and anything accepted that
//     cycle are dropped and flush pulses for one cycle.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : alu_issue_ctrl_if.slave (handshake, ALU, scoreboard, flush)
//   Configuration:
//     ALU_FWD_EN defined   : sources matching the registered ALU result take
//                            alu_wb_data; no ALU-to-ALU stall.
//     ALU_FWD_EN undefined : a dependent op stalls one cycle; alu_wb_* unused.
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_issue_ctrl_if.slave bus
);

    alu_issue_state_e state_q;
    alu_issue_state_e state_d;

    logic      hold_full_q;
    idu1_out_t hold_op_q;

    idu1_out_t cand;
    logic      cand_valid;
    logic      pend_rs1;
    logic      pend_rs2;
    logic      raw_alu;
    logic      hazard;
    logic      issue_now;
    logic      ready;
    logic      accept;
    logic      flush_now;

    // The oldest op is the candidate: the buffered one if present, else the
    // op on the input (zero-bubble path).
    assign cand_valid = hold_full_q | bus.in_valid;
    assign cand       = hold_full_q ? hold_op_q : bus.in_ctrl;

    alu_issue_ctrl_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (bus.sb_set_valid),
        .set_addr  (bus.sb_set_addr),
        .clr_valid (bus.sb_clr_valid),
        .clr_addr  (bus.sb_clr_addr),
        .rd_addr_a (cand.rs1_addr),
        .rd_addr_b (cand.rs2_addr),
        .pend_a    (pend_rs1),
        .pend_b    (pend_rs2)
    );

`ifdef ALU_FWD_EN
    assign raw_alu = 1'b0;
`else
    // Destination of the op issued last cycle; its result is not yet in the
    // register file, so a reader of it must wait one cycle.
    logic              prev_wr_q;
    logic [REG_AW-1:0] prev_rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_wr_q <= 1'b0;
            prev_rd_q <= '0;
        end else begin
            prev_wr_q <= issue_now & cand.rd_wr_en & (cand.rd_addr != '0);
            prev_rd_q <= cand.rd_addr;
        end
    end

    assign raw_alu = prev_wr_q & ((cand.rs1 & (cand.rs1_addr == prev_rd_q)) |
                                  (cand.rs2 & (cand.rs2_addr == prev_rd_q)));

    logic unused_alu_wb;
    assign unused_alu_wb = ^{bus.alu_wb_data, bus.alu_wb_rd_addr, bus.alu_wb_rd_wr_en};
`endif

    assign hazard    = (cand.rs1 & pend_rs1) | (cand.rs2 & pend_rs2) | raw_alu;
    assign issue_now = ~rst & (state_q == IDLE) & cand_valid & ~hazard;
    // Issuing the buffered op frees the slot in the same cycle.
    assign ready     = ~rst & (~hold_full_q | issue_now);
    assign accept    = bus.in_valid & ready;
    assign flush_now = (state_q == RESOLVE) & bus.alu_pc_load;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue_now && (cand.jal || cand.condbr)) state_d = RESOLVE;
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = ready;
        bus.alu_issue = issue_now;
        bus.flush     = ~rst & flush_now;
        bus.alu_ctrl  = nop_ctrl();
        if (issue_now) begin
`ifdef ALU_FWD_EN
            bus.alu_ctrl = fwd_operands(cand, bus.alu_wb_rd_wr_en,
                                        bus.alu_wb_rd_addr, bus.alu_wb_data);
`else
            bus.alu_ctrl = cand;
`endif
        end
    end

    // ---------------- hold buffer ----------------
    // An accepted op is buffered unless it went straight to the ALU.
    logic hold_load;
    assign hold_load = accept & ~(issue_now & ~hold_full_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
        end else if (flush_now) begin
            hold_full_q <= 1'b0;
        end else if (issue_now) begin
            hold_full_q <= hold_full_q & accept;
        end else begin
            hold_full_q <= hold_full_q | accept;
        end
    end

    // NOTE: payload needs no reset; hold_full_q alone qualifies it.
    always_ff @(posedge clk) begin
        if (hold_load) hold_op_q <= bus.in_ctrl;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Self-checking bench for alu_issue_ctrl. A cycle-level reference model
//   (queue of waiting ops, per-register pending flags, last ALU destination)
//   predicts in_ready / alu_issue / flush / alu_ctrl every cycle; directed
//   scenarios add golden sequence checks, then randomized traffic follows.
//   Honours ALU_FWD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic clk;
    logic rst;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // reference model state
    bit        pend_m [NUM_REGS];
    idu1_out_t held_q [$];
    bit        resolve_m;
    bit        last_wr_m;
    logic [REG_AW-1:0] last_rd_m;
    bit        last_accept;

    // last observed DUT outputs, for golden sequence checks
    logic obs_issue;
    logic obs_ready;
    logic obs_flush;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic idu1_out_t mk_op(input logic [3:0] aop, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input bit wr, input bit u1, input bit u2,
                                        input bit jal, input bit br);
        idu1_out_t o;
        o          = '0;
        o.jal      = jal;
        o.condbr   = br;
        o.rs1      = u1;
        o.rs2      = u2;
        o.rs1_addr = ra;
        o.rs2_addr = rb;
        o.rd_wr_en = wr;
        o.rd_addr  = rd;
        o.alu_op   = aop;
        o.rs1_data = $urandom();
        o.rs2_data = $urandom();
        o.imm      = $urandom();
        o.pc       = $urandom();
        return o;
    endfunction

    function automatic idu1_out_t rand_op();
        int k;
        k = $urandom_range(9);
        if (k == 0)
            return mk_op(4'd0, 5'($urandom_range(7)), 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        if (k == 1)
            return mk_op(4'd1, 5'd0, 5'($urandom_range(7)), 5'($urandom_range(7)),
                         1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        return mk_op(4'($urandom_range(15)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                     5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                     1'($urandom_range(1)), 1'b0, 1'b0);
    endfunction

    // One clock cycle: predict, compare at negedge, advance model at posedge.
    task automatic tick();
        idu1_out_t cand;
        idu1_out_t exp_ctrl;
        bit from_hold, have, blocked, e_issue, e_ready, e_flush, accepted;
        exp_ctrl  = nop_ctrl();
        e_issue   = 1'b0;
        e_ready   = 1'b0;
        e_flush   = 1'b0;
        from_hold = (held_q.size() != 0);
        cand      = from_hold ? held_q[0] : bus.in_ctrl;
        have      = from_hold || bus.in_valid;
        if (!rst) begin
            blocked = (cand.rs1 && pend_m[cand.rs1_addr]) || (cand.rs2 && pend_m[cand.rs2_addr]);
`ifndef ALU_FWD_EN
            if (last_wr_m && ((cand.rs1 && cand.rs1_addr == last_rd_m) ||
                              (cand.rs2 && cand.rs2_addr == last_rd_m)))
                blocked = 1'b1;
`endif
            e_issue = !resolve_m && have && !blocked;
            e_ready = !from_hold || e_issue;
            e_flush = resolve_m && bus.alu_pc_load;
            if (e_issue) begin
                exp_ctrl = cand;
`ifdef ALU_FWD_EN
                if (bus.alu_wb_rd_wr_en && bus.alu_wb_rd_addr != 0) begin
                    if (cand.rs1_addr == bus.alu_wb_rd_addr) exp_ctrl.rs1_data = bus.alu_wb_data;
                    if (cand.rs2_addr == bus.alu_wb_rd_addr) exp_ctrl.rs2_data = bus.alu_wb_data;
                end
`endif
            end
        end

        @(negedge clk);
        check("in_ready",  256'(bus.in_ready),  256'(e_ready));
        check("alu_issue", 256'(bus.alu_issue), 256'(e_issue));
        check("flush",     256'(bus.flush),     256'(e_flush));
        check("alu_ctrl",  256'(bus.alu_ctrl),  256'(exp_ctrl));
        obs_issue = bus.alu_issue;
        obs_ready = bus.in_ready;
        obs_flush = bus.flush;

        @(posedge clk);
        accepted = bus.in_valid && e_ready;
        if (rst) begin
            foreach (pend_m[i]) pend_m[i] = 1'b0;
            held_q.delete();
            resolve_m = 1'b0;
            last_wr_m = 1'b0;
            last_rd_m = '0;
        end else begin
            if (e_issue && from_hold) void'(held_q.pop_front());
            if (accepted && !(e_issue && !from_hold)) held_q.push_back(bus.in_ctrl);
            if (e_flush) held_q.delete();
            if (bus.sb_clr_valid && bus.sb_clr_addr != 0) pend_m[bus.sb_clr_addr] = 1'b0;
            if (bus.sb_set_valid && bus.sb_set_addr != 0) pend_m[bus.sb_set_addr] = 1'b1;
            resolve_m = e_issue && (cand.jal || cand.condbr);
            last_wr_m = e_issue && cand.rd_wr_en && (cand.rd_addr != 0);
            last_rd_m = cand.rd_addr;
        end
        last_accept = accepted;
        #1;
        // registered ALU result of whatever issued last cycle
        bus.alu_wb_rd_wr_en = last_wr_m;
        bus.alu_wb_rd_addr  = last_rd_m;
        bus.alu_wb_data     = $urandom();
    endtask

    task automatic quiet(input int n);
        bus.in_valid     = 1'b0;
        bus.sb_set_valid = 1'b0;
        bus.sb_clr_valid = 1'b0;
        bus.alu_pc_load  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [2:0] seq;
        n_vec = 0;
        n_err = 0;
        resolve_m = 1'b0;
        last_wr_m = 1'b0;
        last_rd_m = '0;
        last_accept = 1'b0;
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        bus.in_valid        = 1'b0;
        bus.in_ctrl         = '0;
        bus.sb_set_valid    = 1'b0;
        bus.sb_set_addr     = '0;
        bus.sb_clr_valid    = 1'b0;
        bus.sb_clr_addr     = '0;
        bus.alu_wb_data     = '0;
        bus.alu_wb_rd_addr  = '0;
        bus.alu_wb_rd_wr_en = 1'b0;
        bus.alu_pc_load     = 1'b0;

        // ---- reset ----
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_ctrl  = mk_op(4'd2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("rst_ready", 256'(obs_ready), 256'(1'b0));
        check("rst_issue", 256'(obs_issue), 256'(1'b0));
        tick();
        rst = 1'b0;
        quiet(1);
        check("post_rst_ready", 256'(obs_ready), 256'(1'b1));

        // ---- add x1,x2,x3 ; add x4,x1,x1 ----
        bus.in_valid = 1'b1;
        bus.in_ctrl  = mk_op(4'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); seq[2] = obs_issue;
        bus.in_ctrl  = mk_op(4'd0, 5'd4, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); seq[1] = obs_issue;
        bus.in_valid = 1'b0;
        tick(); seq[0] = obs_issue;
`ifdef ALU_FWD_EN
        check("raw_seq", 256'(seq), 256'(3'b110));
`else
        check("raw_seq", 256'(seq), 256'(3'b101));
`endif
        quiet(2);

        // ---- scoreboard hold: set x5, add x6,x5,x0, clr x5 at cycle 4 ----
        bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd5;
        tick();                                           // cycle 0
        bus.sb_set_valid = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_ctrl  = mk_op(4'd0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();                                           // cycle 1
        check("sb_c1_issue", 256'(obs_issue), 256'(1'b0));
        bus.in_ctrl  = mk_op(4'd3, 5'd8, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();                                           // cycle 2
        check("sb_c2_ready", 256'(obs_ready), 256'(1'b0));
        tick();                                           // cycle 3
        check("sb_c3_ready", 256'(obs_ready), 256'(1'b0));
        bus.sb_clr_valid = 1'b1; bus.sb_clr_addr = 5'd5;
        tick();                                           // cycle 4
        check("sb_c4_issue", 256'(obs_issue), 256'(1'b0));
        bus.sb_clr_valid = 1'b0;
        tick();                                           // cycle 5
        check("sb_c5_issue", 256'(obs_issue), 256'(1'b1));
        check("sb_c5_ready", 256'(obs_ready), 256'(1'b1));
        quiet(3);

        // ---- beq taken: flush, following op dropped ----
        bus.in_valid = 1'b1;
        bus.in_ctrl  = mk_op(4'd1, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("beq_issue", 256'(obs_issue), 256'(1'b1));
        bus.in_ctrl  = mk_op(4'd0, 5'd9, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.alu_pc_load = 1'b1;
        tick();
        check("beq_flush", 256'(obs_flush), 256'(1'b1));
        check("beq_res_issue", 256'(obs_issue), 256'(1'b0));
        bus.in_valid = 1'b0;
        bus.alu_pc_load = 1'b0;
        tick();
        check("beq_dropped", 256'(obs_issue), 256'(1'b0));
        check("beq_flush_end", 256'(obs_flush), 256'(1'b0));
        quiet(2);

        // ---- bne not taken: one bubble ----
        bus.in_valid = 1'b1;
        bus.in_ctrl  = mk_op(4'd1, 5'd0, 5'd3, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        bus.in_ctrl  = mk_op(4'd0, 5'd10, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("bne_bubble", 256'(obs_issue), 256'(1'b0));
        check("bne_noflush", 256'(obs_flush), 256'(1'b0));
        bus.in_valid = 1'b0;
        tick();
        check("bne_next_issue", 256'(obs_issue), 256'(1'b1));
        quiet(2);

        // ---- set and clr x7 in the same cycle: set wins ----
        bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd7;
        bus.sb_clr_valid = 1'b1; bus.sb_clr_addr = 5'd7;
        tick();
        bus.sb_set_valid = 1'b0;
        bus.sb_clr_valid = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_ctrl  = mk_op(4'd0, 5'd11, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("x7_stall", 256'(obs_issue), 256'(1'b0));
        bus.in_valid = 1'b0;
        tick();
        check("x7_still", 256'(obs_issue), 256'(1'b0));
        bus.sb_clr_valid = 1'b1; bus.sb_clr_addr = 5'd7;
        tick();
        bus.sb_clr_valid = 1'b0;
        tick();
        check("x7_release", 256'(obs_issue), 256'(1'b1));
        quiet(2);

        // ---- reset during RESOLVE with a redirect ----
        bus.sb_set_valid = 1'b1; bus.sb_set_addr = 5'd9;
        tick();
        bus.sb_set_valid = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_ctrl  = mk_op(4'd0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("jal_issue", 256'(obs_issue), 256'(1'b1));
        rst = 1'b1;
        bus.alu_pc_load = 1'b1;
        bus.in_ctrl  = mk_op(4'd0, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("rst_res_flush", 256'(obs_flush), 256'(1'b0));
        check("rst_res_issue", 256'(obs_issue), 256'(1'b0));
        rst = 1'b0;
        bus.alu_pc_load = 1'b0;
        bus.in_ctrl  = mk_op(4'd0, 5'd10, 5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("sb_cleared", 256'(obs_issue), 256'(1'b1));
        quiet(2);

        // ---- randomized traffic ----
        for (int n = 0; n < 600; n++) begin
            if (!(bus.in_valid && !last_accept)) begin
                bus.in_valid = ($urandom_range(9) < 7);
                bus.in_ctrl  = rand_op();
            end
            bus.sb_set_valid = ($urandom_range(4) == 0);
            bus.sb_set_addr  = 5'($urandom_range(7));
            bus.sb_clr_valid = ($urandom_range(2) == 0);
            bus.sb_clr_addr  = 5'($urandom_range(7));
            bus.alu_pc_load  = 1'($urandom_range(1));
            rst = ($urandom_range(99) == 0);
            tick();
        end
        rst = 1'b0;
        quiet(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
